// File: rtl/multdiv_issue_ctrl_if.sv
// Execute-stage request, writeback and iterative mult/div unit signals
// of the issue sequencer, bundled for a single port connection.
interface multdiv_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [REGW-1:0]  rd;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             stall;
  logic             wb_valid;
  logic [REGW-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             busy;

  modport slave (
    input  start_mult, start_div, op_a, op_b, rd,
           data_result, data_exception, data_resultRDY,
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
           stall, wb_valid, wb_rd, wb_data, busy
  );

  modport master (
    output start_mult, start_div, op_a, op_b, rd,
           data_result, data_exception, data_resultRDY,
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
           stall, wb_valid, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issue/writeback sequencer in front of the iterative mult/div unit:
// latches a request, pulses start, waits for ready (with watchdog), writes back.
module multdiv_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int REGW      = 5,
  parameter int MAX_WAIT  = 40,
  parameter int EXC_REG   = 30,
  parameter int MULT_CODE = 4,
  parameter int DIV_CODE  = 5
) (
  input logic                 clock,
  input logic                 reset,
  multdiv_issue_ctrl_if.slave bus
);
  localparam int               CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic [REGW-1:0]  rd_q;
  logic             is_div_q;
  logic             exc_q;
  logic [CNT_W-1:0] wait_cnt;

  function automatic logic [WIDTH-1:0] exc_code(input logic is_div);
    return is_div ? WIDTH'(DIV_CODE) : WIDTH'(MULT_CODE);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // multiply has priority when both requests arrive together
          if (bus.start_mult) begin
            opa_q    <= bus.op_a;
            opb_q    <= bus.op_b;
            rd_q     <= bus.rd;
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
            state    <= ISSUE;
          end else if (bus.start_div) begin
            is_div_q <= 1'b1;
            if (bus.op_b == '0) begin
              // divide-by-zero never reaches the unit
              exc_q <= 1'b1;
              state <= DONE;
            end else begin
              opa_q <= bus.op_a;
              opb_q <= bus.op_b;
              rd_q  <= bus.rd;
              exc_q <= 1'b0;
              state <= ISSUE;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // a ready still high from the previous operation is ignored here
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (bus.data_resultRDY) begin
            res_q <= bus.data_result;
            exc_q <= bus.data_exception;
            state <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            exc_q <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_MULT     = (state == ISSUE) & ~is_div_q;
  assign bus.ctrl_DIV      = (state == ISSUE) & is_div_q;
  assign bus.data_operandA = opa_q;
  assign bus.data_operandB = opb_q;
  assign bus.busy          = (state != IDLE);
  // stall drops in DONE so the following instruction advances with writeback
  assign bus.stall         = bus.start_mult | bus.start_div | (state == ISSUE) | (state == WAIT);
  assign bus.wb_valid      = (state == DONE);
  assign bus.wb_rd         = (state != DONE) ? '0 : (exc_q ? REGW'(EXC_REG) : rd_q);
  assign bus.wb_data       = (state != DONE) ? '0 : (exc_q ? exc_code(is_div_q) : res_q);
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: transaction-timeline reference model, per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_multdiv_issue_ctrl;
  localparam int WIDTH     = 32;
  localparam int REGW      = 5;
  localparam int MAX_WAIT  = 40;
  localparam int EXC_REG   = 30;
  localparam int MULT_CODE = 4;
  localparam int DIV_CODE  = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multdiv_issue_ctrl_if #(.WIDTH(WIDTH), .REGW(REGW)) bus();

  multdiv_issue_ctrl #(
    .WIDTH(WIDTH), .REGW(REGW), .MAX_WAIT(MAX_WAIT),
    .EXC_REG(EXC_REG), .MULT_CODE(MULT_CODE), .DIV_CODE(DIV_CODE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // One in-flight operation described by when it was accepted and when the
  // unit answers; every per-cycle expectation is derived from these times.
  typedef struct {
    bit               active;
    int               acc;
    bit               is_div;
    bit               dz;
    logic [REGW-1:0]  rd;
    int               rdy_cyc;
    logic [WIDTH-1:0] res;
    bit               exc;
  } op_t;

  op_t              cur;
  logic [WIDTH-1:0] m_opa, m_opb;
  int               cyc;
  bit               run;
  int               n_chk, n_fail;
  int               nx_lat;
  logic [WIDTH-1:0] nx_res;
  bit               nx_exc;
  bit               noise_one;

  logic             s_cm, s_cd, s_stall, s_wbv, s_busy;
  logic [REGW-1:0]  s_wbrd;
  logic [WIDTH-1:0] s_wbd, s_opa, s_opb;

  function automatic bit answered_in_time();
    return (cur.rdy_cyc - (cur.acc + 2)) < MAX_WAIT;
  endfunction

  function automatic int done_cyc();
    if (cur.dz) return cur.acc + 1;
    if (answered_in_time()) return cur.rdy_cyc + 1;
    return cur.acc + 2 + MAX_WAIT;
  endfunction

  function automatic bit exc_final();
    if (cur.dz) return 1'b1;
    if (answered_in_time()) return cur.exc;
    return 1'b1;
  endfunction

  function automatic bit in_op(input int c);
    return cur.active && (c > cur.acc) && (c <= done_cyc());
  endfunction

  function automatic bit in_issue(input int c);
    return in_op(c) && !cur.dz && (c == cur.acc + 1);
  endfunction

  function automatic bit in_wait(input int c);
    return in_op(c) && !cur.dz && (c >= cur.acc + 2) && (c < done_cyc());
  endfunction

  function automatic bit in_done(input int c);
    return in_op(c) && (c == done_cyc());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=0x%h required=0x%h", name, cyc, act, req);
    end
  endtask

  always @(negedge clock) begin
    logic [REGW-1:0]  erd;
    logic [WIDTH-1:0] ed;
    if (run) begin
      erd = '0;
      ed  = '0;
      if (in_done(cyc)) begin
        if (exc_final()) begin
          erd = REGW'(EXC_REG);
          ed  = cur.is_div ? WIDTH'(DIV_CODE) : WIDTH'(MULT_CODE);
        end else begin
          erd = cur.rd;
          ed  = cur.res;
        end
      end
      chk("ctrl_MULT", 32'(bus.ctrl_MULT), 32'(in_issue(cyc) && !cur.is_div));
      chk("ctrl_DIV",  32'(bus.ctrl_DIV),  32'(in_issue(cyc) && cur.is_div));
      chk("busy",      32'(bus.busy),      32'(in_op(cyc)));
      chk("stall",     32'(bus.stall),
          32'(bus.start_mult | bus.start_div | in_issue(cyc) | in_wait(cyc)));
      chk("wb_valid",  32'(bus.wb_valid),  32'(in_done(cyc)));
      chk("wb_rd",     32'(bus.wb_rd),     32'(erd));
      chk("wb_data",   bus.wb_data,        ed);
      chk("operandA",  bus.data_operandA,  m_opa);
      chk("operandB",  bus.data_operandB,  m_opb);
    end
  end

  task automatic step(input bit sm, input bit sd, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [REGW-1:0] r, input bit rst_i);
    bit hit;
    @(posedge clock);
    cyc++;
    #1;
    reset          = rst_i;
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.rd         = r;
    if (in_wait(cyc)) begin
      hit                = (cyc == cur.rdy_cyc);
      bus.data_resultRDY = hit;
      bus.data_result    = hit ? cur.res : $urandom;
      bus.data_exception = hit ? cur.exc : 1'($urandom);
    end else begin
      bus.data_resultRDY = noise_one ? 1'b1 : 1'($urandom);
      bus.data_result    = $urandom;
      bus.data_exception = 1'($urandom);
    end
    @(negedge clock);
    #1;
    s_cm = bus.ctrl_MULT;  s_cd = bus.ctrl_DIV;  s_stall = bus.stall;
    s_wbv = bus.wb_valid;  s_busy = bus.busy;    s_wbrd = bus.wb_rd;
    s_wbd = bus.wb_data;   s_opa = bus.data_operandA;  s_opb = bus.data_operandB;
    if (rst_i) begin
      cur.active = 1'b0;
      m_opa      = '0;
      m_opb      = '0;
    end else if ((sm || sd) && !(in_issue(cyc) || in_wait(cyc))) begin
      cur.active  = 1'b1;
      cur.acc     = cyc;
      cur.is_div  = !sm;
      cur.dz      = !sm && (b == '0);
      cur.rd      = r;
      cur.rdy_cyc = cyc + 1 + nx_lat;
      cur.res     = nx_res;
      cur.exc     = nx_exc;
      if (!cur.dz) begin
        m_opa = a;
        m_opb = b;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom, REGW'($urandom), 1'b0);
  endtask

  task automatic wait_wb(input int budget, output int at, output int ncm, output int ncd,
                         output int nst, output logic [REGW-1:0] wrd,
                         output logic [WIDTH-1:0] wd, output int nchg,
                         output logic [WIDTH-1:0] opb0);
    at = -1; ncm = 0; ncd = 0; nst = 0; nchg = 0; wrd = '0; wd = '0; opb0 = '0;
    for (int i = 0; i < budget; i++) begin
      idle(1);
      if (i == 0) opb0 = s_opb;
      else if (s_opb !== opb0) nchg++;
      if (s_cm) ncm++;
      if (s_cd) ncd++;
      if (s_wbv) begin
        at = cyc; wrd = s_wbrd; wd = s_wbd;
        break;
      end
      if (s_stall) nst++;
    end
    if (at < 0) chk("wb_within_budget", 32'(0), 32'(1));
  endtask

  initial begin
    int at, ncm, ncd, nst, nchg, a0, nwb;
    logic [REGW-1:0]  wrd;
    logic [WIDTH-1:0] wd, opb0;

    n_chk = 0; n_fail = 0; cyc = 0; run = 1'b1; noise_one = 1'b0;
    cur.active = 1'b0; cur.acc = 0; cur.is_div = 1'b0; cur.dz = 1'b0; cur.rd = '0;
    cur.rdy_cyc = 0; cur.res = '0; cur.exc = 1'b0;
    m_opa = '0; m_opb = '0;
    nx_lat = 1; nx_res = '0; nx_exc = 1'b0;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.rd = '0;
    bus.data_result = '0; bus.data_exception = 1'b0; bus.data_resultRDY = 1'b0;

    // reset held three cycles, then everything quiet and zero
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(1);
    chk("rst_ctrl_MULT", 32'(s_cm), 32'(0));
    chk("rst_ctrl_DIV",  32'(s_cd), 32'(0));
    chk("rst_stall",     32'(s_stall), 32'(0));
    chk("rst_wb_valid",  32'(s_wbv), 32'(0));
    chk("rst_busy",      32'(s_busy), 32'(0));
    chk("rst_wb_rd",     32'(s_wbrd), 32'(0));
    chk("rst_wb_data",   s_wbd, 32'(0));
    chk("rst_operandA",  s_opa, 32'(0));
    chk("rst_operandB",  s_opb, 32'(0));

    // divide 100/7 -> 14, unit answers 17 cycles after ctrl_DIV
    nx_lat = 17; nx_res = 32'd14; nx_exc = 1'b0;
    step(1'b0, 1'b1, 32'd100, 32'd7, 5'd3, 1'b0); a0 = cyc;
    wait_wb(40, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("div_ctrl_DIV_cycles", 32'(ncd), 32'(1));
    chk("div_ctrl_MULT_cycles", 32'(ncm), 32'(0));
    chk("div_wb_latency", 32'(at - a0), 32'(19));
    chk("div_stall_cycles", 32'(nst), 32'(18));
    chk("div_operandB", opb0, 32'd7);
    chk("div_operandB_changes", 32'(nchg), 32'(0));
    chk("div_wb_rd", 32'(wrd), 32'(3));
    chk("div_wb_data", wd, 32'd14);
    idle(1);
    chk("div_wb_single", 32'(s_wbv), 32'(0));

    // divide by zero: straight to writeback of DIV_CODE
    nx_lat = 5; nx_res = $urandom; nx_exc = 1'b0;
    step(1'b0, 1'b1, 32'd9, 32'd0, 5'd8, 1'b0); a0 = cyc;
    wait_wb(5, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("dz_wb_latency", 32'(at - a0), 32'(1));
    chk("dz_ctrl_DIV_cycles", 32'(ncd), 32'(0));
    chk("dz_wb_rd", 32'(wrd), 32'(30));
    chk("dz_wb_data", wd, 32'd5);

    // multiply with unit exception
    nx_lat = 3; nx_res = $urandom; nx_exc = 1'b1;
    step(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd2, 1'b0); a0 = cyc;
    wait_wb(20, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("mexc_ctrl_MULT_cycles", 32'(ncm), 32'(1));
    chk("mexc_wb_latency", 32'(at - a0), 32'(5));
    chk("mexc_wb_rd", 32'(wrd), 32'(30));
    chk("mexc_wb_data", wd, 32'd4);

    // stale ready held high, then back-to-back request in the DONE cycle
    noise_one = 1'b1;
    nx_lat = 4; nx_res = 32'h0000_1234; nx_exc = 1'b0;
    step(1'b1, 1'b0, 32'd11, 32'd22, 5'd9, 1'b0); a0 = cyc;
    idle(5);
    nx_lat = 2; nx_res = 32'd55; nx_exc = 1'b0;
    step(1'b1, 1'b0, 32'd33, 32'd44, 5'd12, 1'b0);
    chk("stale_done_wb_valid", 32'(s_wbv), 32'(1));
    chk("stale_done_wb_data", s_wbd, 32'h0000_1234);
    chk("stale_done_wb_rd", 32'(s_wbrd), 32'(9));
    noise_one = 1'b0;
    idle(1);
    chk("b2b_issue_ctrl_MULT", 32'(s_cm), 32'(1));
    chk("b2b_issue_operandB", s_opb, 32'd44);
    wait_wb(10, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("b2b_wb_data", wd, 32'd55);

    // watchdog: unit never answers a divide
    nx_lat = 1000; nx_res = $urandom; nx_exc = 1'b0;
    step(1'b0, 1'b1, 32'd50, 32'd3, 5'd6, 1'b0); a0 = cyc;
    wait_wb(60, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("tmo_wb_latency", 32'(at - a0), 32'(42));
    chk("tmo_wb_rd", 32'(wrd), 32'(30));
    chk("tmo_wb_data", wd, 32'd5);

    // ready in the very last WAIT cycle still counts as a normal answer
    nx_lat = 40; nx_res = 32'hCAFE_0001; nx_exc = 1'b0;
    step(1'b1, 1'b0, 32'd7, 32'd8, 5'd4, 1'b0); a0 = cyc;
    wait_wb(60, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("edge_wb_latency", 32'(at - a0), 32'(42));
    chk("edge_wb_rd", 32'(wrd), 32'(4));
    chk("edge_wb_data", wd, 32'hCAFE_0001);

    // simultaneous requests: multiply wins
    nx_lat = 2; nx_res = 32'd77; nx_exc = 1'b0;
    step(1'b1, 1'b1, 32'd5, 32'd6, 5'd7, 1'b0);
    wait_wb(10, at, ncm, ncd, nst, wrd, wd, nchg, opb0);
    chk("prio_ctrl_MULT_cycles", 32'(ncm), 32'(1));
    chk("prio_ctrl_DIV_cycles", 32'(ncd), 32'(0));
    chk("prio_wb_rd", 32'(wrd), 32'(7));

    // reset during WAIT drops the operation without writeback
    nx_lat = 20; nx_res = $urandom; nx_exc = 1'b0;
    step(1'b1, 1'b0, 32'd1, 32'd2, 5'd1, 1'b0);
    idle(5);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    nwb = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (i == 0) chk("rstwait_busy", 32'(s_busy), 32'(0));
      if (s_wbv) nwb++;
    end
    chk("rstwait_no_wb", 32'(nwb), 32'(0));

    // randomized traffic, including requests while busy and rare resets
    for (int i = 0; i < 1500; i++) begin
      int k, lsel;
      bit sm, sd, rs;
      logic [WIDTH-1:0] b;
      k  = $urandom_range(0, 99);
      sm = (k < 12) || (k >= 24 && k < 27);
      sd = (k >= 12 && k < 27);
      b  = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
      lsel = $urandom_range(0, 9);
      if (lsel < 7)      nx_lat = $urandom_range(1, 8);
      else if (lsel < 9) nx_lat = $urandom_range(36, 44);
      else               nx_lat = 200;
      nx_res = $urandom;
      nx_exc = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(sm, sd, $urandom, b, REGW'($urandom), rs);
    end

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
